// File: rtl/ccx_timer_pkg.sv
// Shared definitions for the ccx_mmio_timer block: register offsets, ctrl field layout,
// grant FSM states and the byte-lane merge helper.
package ccx_timer_pkg;

    localparam logic [4:0] OFF_MTIME    = 5'h00;
    localparam logic [4:0] OFF_MTIMECMP = 5'h08;
    localparam logic [4:0] OFF_CTRL     = 5'h10;
    localparam logic [4:0] OFF_STATUS   = 5'h18;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;
    localparam int unsigned CTRL_PRESCALE_W   = 8;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ccx_timer_prescaler.sv
// Prescaler for the machine timer: emits one tick every (prescale + 1) enabled cycles.
// clr_i restarts the count from zero, e.g. when ctrl is rewritten.
module ccx_timer_prescaler
    import ccx_timer_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [CTRL_PRESCALE_W-1:0] prescale_i,
    input  logic                       clr_i,
    output logic                       tick_o
);

    logic [CTRL_PRESCALE_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == prescale_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ccx_mmio_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp/ctrl/status) on the core_mem_bus responder port.
// Define CCX_TIMER_MISALIGN_ERR_EN to reject accesses with addr[2:0] != 0 instead of aliasing.
module ccx_mmio_timer #(
    parameter int unsigned AW           = 39,
    parameter int unsigned DW           = 64,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter int unsigned PRESCALE_RST = 0
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            if_mmio_req_i,
    output logic            if_mmio_gnt_o,
    input  logic [AW-1:0]   if_mmio_addr_i,
    input  logic            if_mmio_wen_i,
    input  logic [DW/8-1:0] if_mmio_strb_i,
    input  logic [DW-1:0]   if_mmio_wdata_i,
    input  logic            if_mmio_rtype_i,
    output logic [DW-1:0]   if_mmio_rdata_o,
    output logic            if_mmio_err_o,
    output logic            irq_timer_o
);
    import ccx_timer_pkg::*;

    localparam logic [3:0] WaitLast = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e                     state_q;
    logic [3:0]                 wcnt_q;
    logic                       gnt;
    logic                       acc;

    logic [DW-1:0]              mtime_q;
    logic [DW-1:0]              mtimecmp_q;
    logic                       en_q;
    logic [CTRL_PRESCALE_W-1:0] prescale_q;
    logic                       irq_q;
    logic                       rsp_v_q;
    logic [DW-1:0]              rdata_q;
    logic                       err_q;

    logic [4:0]                 off;
    logic                       addr_bad;
    logic                       sel_mtime, sel_cmp, sel_ctrl;
    logic                       acc_err;
    logic [DW-1:0]              rd_val;
    logic [DW-1:0]              ctrl_rd;
    logic                       wr_en;
    logic                       mtime_wr, cmp_wr, ctrl_wr;
    logic                       tick;
    logic                       unused_bits;

    // Grant: combinational pass-through with no wait states, else stall WAIT_CYCLES cycles.
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            gnt = if_mmio_req_i;
        end else begin
            gnt = if_mmio_req_i && (state_q == ST_WAIT) && (wcnt_q == WaitLast);
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else if (WAIT_CYCLES != 0) begin
            case (state_q)
                ST_IDLE: begin
                    if (if_mmio_req_i) begin
                        state_q <= ST_WAIT;
                        wcnt_q  <= '0;
                    end
                end
                ST_WAIT: begin
                    // A dropped request abandons the access without granting it.
                    if (!if_mmio_req_i || (wcnt_q == WaitLast)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign acc           = if_mmio_req_i && gnt;
    assign if_mmio_gnt_o = gnt;
    assign off           = {if_mmio_addr_i[4:3], 3'b000};

`ifdef CCX_TIMER_MISALIGN_ERR_EN
    assign addr_bad    = |if_mmio_addr_i[2:0];
    assign unused_bits = ^{if_mmio_addr_i[AW-1:5], if_mmio_rtype_i};
`else
    assign addr_bad    = 1'b0;
    assign unused_bits = ^{if_mmio_addr_i[AW-1:5], if_mmio_addr_i[2:0], if_mmio_rtype_i};
`endif

    always_comb begin
        ctrl_rd                                        = '0;
        ctrl_rd[CTRL_EN_BIT]                           = en_q;
        ctrl_rd[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W]  = prescale_q;
    end

    always_comb begin
        sel_mtime = 1'b0;
        sel_cmp   = 1'b0;
        sel_ctrl  = 1'b0;
        acc_err   = 1'b0;
        rd_val    = '0;
        if (addr_bad) begin
            acc_err = 1'b1;
        end else begin
            case (off)
                OFF_MTIME: begin
                    sel_mtime = 1'b1;
                    rd_val    = mtime_q;
                end
                OFF_MTIMECMP: begin
                    sel_cmp = 1'b1;
                    rd_val  = mtimecmp_q;
                end
                OFF_CTRL: begin
                    sel_ctrl = 1'b1;
                    rd_val   = ctrl_rd;
                end
                OFF_STATUS: begin
                    rd_val = {{(DW-1){1'b0}}, irq_q};
                end
                default: acc_err = 1'b1;
            endcase
        end
    end

    // An all-zero strobe is a true no-op: it neither suppresses a tick nor clears the prescaler.
    assign wr_en    = acc && if_mmio_wen_i && (|if_mmio_strb_i);
    assign mtime_wr = wr_en && sel_mtime;
    assign cmp_wr   = wr_en && sel_cmp;
    assign ctrl_wr  = wr_en && sel_ctrl;

    ccx_timer_prescaler u_prescaler (
        .clk_i      (g_clk),
        .rst_i      (g_reset),
        .en_i       (en_q),
        .prescale_i (prescale_q),
        .clr_i      (ctrl_wr),
        .tick_o     (tick)
    );

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            prescale_q <= CTRL_PRESCALE_W'(PRESCALE_RST);
            irq_q      <= 1'b0;
            rsp_v_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (mtime_wr) begin
                mtime_q <= byte_merge(mtime_q, if_mmio_wdata_i, if_mmio_strb_i);
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end
            if (cmp_wr) begin
                mtimecmp_q <= byte_merge(mtimecmp_q, if_mmio_wdata_i, if_mmio_strb_i);
            end
            if (ctrl_wr) begin
                if (if_mmio_strb_i[CTRL_EN_BIT/8]) begin
                    en_q <= if_mmio_wdata_i[CTRL_EN_BIT];
                end
                if (if_mmio_strb_i[CTRL_PRESCALE_LSB/8]) begin
                    prescale_q <= if_mmio_wdata_i[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W];
                end
            end
            irq_q   <= (mtime_q >= mtimecmp_q);
            rsp_v_q <= acc;
            if (acc) begin
                rdata_q <= if_mmio_wen_i ? '0 : rd_val;
                err_q   <= acc_err;
            end
        end
    end

    assign if_mmio_rdata_o = rsp_v_q ? rdata_q : '0;
    assign if_mmio_err_o   = rsp_v_q && err_q;
    assign irq_timer_o     = irq_q;

endmodule

// File: tb/tb_ccx_mmio_timer.sv
// Randomized scoreboard bench for ccx_mmio_timer with a cycle-arithmetic reference model;
// a second instance with WAIT_CYCLES=2 checks grant stalling.
module tb_ccx_mmio_timer;

    localparam int AW = 39;

    typedef struct {
        logic        is_rd;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          g_reset = 1'b1;
    longint        cyc = 0;

    logic          req = 1'b0, wen = 1'b0, rtype = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    strb = '0;
    logic [63:0]   wdata = '0;
    logic          gnt, err, irq;
    logic [63:0]   rdata;

    logic          req2 = 1'b0;
    logic [AW-1:0] addr2 = '0;
    logic          gnt2, err2, irq2;
    logic [63:0]   rdata2;

    int            checks = 0;
    int            failures = 0;
    exp_t          exp_q[$];
    logic          mon_en = 1'b0;
    logic          pend = 1'b0;

    // Reference model: mtime(c) = base + number of prescaler ticks in cycles [m_ma, c).
    logic [63:0]   m_base, m_cmp;
    longint        m_ma, m_cs;
    int            m_p1;
    logic          m_en;
    logic [7:0]    m_ps;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ccx_mmio_timer #(.AW(AW), .DW(64), .WAIT_CYCLES(0), .PRESCALE_RST(0)) dut (
        .g_clk(clk), .g_reset(g_reset),
        .if_mmio_req_i(req), .if_mmio_gnt_o(gnt), .if_mmio_addr_i(addr),
        .if_mmio_wen_i(wen), .if_mmio_strb_i(strb), .if_mmio_wdata_i(wdata),
        .if_mmio_rtype_i(rtype), .if_mmio_rdata_o(rdata), .if_mmio_err_o(err),
        .irq_timer_o(irq)
    );

    ccx_mmio_timer #(.AW(AW), .DW(64), .WAIT_CYCLES(2), .PRESCALE_RST(0)) dut2 (
        .g_clk(clk), .g_reset(g_reset),
        .if_mmio_req_i(req2), .if_mmio_gnt_o(gnt2), .if_mmio_addr_i(addr2),
        .if_mmio_wen_i(1'b0), .if_mmio_strb_i(8'h00), .if_mmio_wdata_i(64'h0),
        .if_mmio_rtype_i(1'b0), .if_mmio_rdata_o(rdata2), .if_mmio_err_o(err2),
        .irq_timer_o(irq2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] s);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_at(input longint c);
        longint n;
        if (!m_en) return m_base;
        n = ((c - m_cs) / m_p1) - ((m_ma - m_cs) / m_p1);
        return m_base + 64'(n);
    endfunction

    function automatic logic [63:0] m_ctrl();
        return {48'h0, m_ps, 7'h0, m_en};
    endfunction

    task automatic xact(input logic w, input logic [AW-1:0] a, input logic [7:0] s,
                        input logic [63:0] d);
        exp_t        e;
        longint      g;
        logic        bad;
        logic [63:0] nv;
        @(negedge clk);
        req = 1'b1; wen = w; addr = a; strb = s; wdata = d; rtype = 1'($urandom());
        #1;
        check("gnt_same_cycle", {63'h0, gnt}, 64'h1);
        if (gnt) begin
            g = cyc;
`ifdef CCX_TIMER_MISALIGN_ERR_EN
            bad = (a[2:0] != 3'b000);
`else
            bad = 1'b0;
`endif
            e.is_rd = !w;
            e.rdata = '0;
            e.err   = bad;
            if (!bad && !w) begin
                case (a[4:3])
                    2'd0: e.rdata = m_at(g);
                    2'd1: e.rdata = m_cmp;
                    2'd2: e.rdata = m_ctrl();
                    default: e.rdata = {63'h0, (m_at(g - 1) >= m_cmp)};
                endcase
            end else if (!bad && s != 8'h00) begin
                case (a[4:3])
                    2'd0: begin
                        m_base = merge(m_at(g), d, s);
                        m_ma   = g + 1;
                    end
                    2'd1: m_cmp = merge(m_cmp, d, s);
                    2'd2: begin
                        nv     = merge(m_ctrl(), d, s);
                        m_base = m_at(g + 1);
                        m_ma   = g + 1;
                        m_cs   = g + 1;
                        m_en   = nv[0];
                        m_ps   = nv[15:8];
                        m_p1   = int'(m_ps) + 1;
                    end
                    default: ;
                endcase
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    // Idle cycles; irq is checked in each since the last grant is at least two cycles back.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check("irq_level", {63'h0, irq}, {63'h0, (m_at(cyc - 1) >= m_cmp)});
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 64'h1, 64'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_rd) check("rsp_rdata", rdata, e.rdata);
                    check("rsp_err", {63'h0, err}, {63'h0, e.err});
                end
            end else begin
                check("idle_rdata", rdata, 64'h0);
                check("idle_err", {63'h0, err}, 64'h0);
            end
            pend = req && gnt;
        end
    end

    initial begin
        logic [AW-1:0] a;
        logic [63:0]   d;
        logic [7:0]    s;
        logic [1:0]    sel;
        int            r;

        repeat (4) @(negedge clk);
        #1;
        check("rst_rdata", rdata, 64'h0);
        check("rst_err", {63'h0, err}, 64'h0);
        check("rst_irq", {63'h0, irq}, 64'h0);
        check("rst_gnt", {63'h0, gnt}, 64'h0);
        check("rst_irq2", {63'h0, irq2}, 64'h0);
        check("rst_gnt2", {63'h0, gnt2}, 64'h0);
        g_reset = 1'b0;
        m_base = '0; m_cmp = '1; m_ma = 0; m_cs = 0; m_en = 1'b0; m_ps = 8'h0; m_p1 = 1;
        mon_en = 1'b1;

        // WAIT_CYCLES=2 instance: grant on the 3rd held cycle, response on the 4th.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req2 = 1'b1;
            addr2 = (k == 0) ? 39'h18 : 39'h08;
            #1 check("w2_gnt_c1", {63'h0, gnt2}, 64'h0);
            @(negedge clk); #1 check("w2_gnt_c2", {63'h0, gnt2}, 64'h0);
            @(negedge clk); #1 check("w2_gnt_c3", {63'h0, gnt2}, 64'h1);
            @(negedge clk);
            req2 = 1'b0;
            #1;
            check("w2_rdata", rdata2, (k == 0) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF);
            check("w2_err", {63'h0, err2}, 64'h0);
            @(negedge clk); #1 check("w2_idle_rdata", rdata2, 64'h0);
        end

        xact(1'b0, 39'h08, 8'h00, 64'h0);
        gap(1);
        xact(1'b1, 39'h10, 8'hFF, 64'h0301);
        gap(16);
        xact(1'b0, 39'h00, 8'h00, 64'h0);
        gap(1);
        xact(1'b0, 39'h18, 8'h00, 64'h0);
        gap(1);
        xact(1'b1, 39'h08, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        gap(1);
        xact(1'b1, 39'h08, 8'h0F, 64'h1122_3344_5566_7788);
        gap(1);
        xact(1'b0, 39'h08, 8'h00, 64'h0);
        gap(1);
        xact(1'b1, 39'h10, 8'hFF, 64'h0001);
        gap(1);
        xact(1'b1, 39'h08, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        gap(1);
        xact(1'b1, 39'h00, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        gap(4);
        xact(1'b0, 39'h00, 8'h00, 64'h0);
        gap(1);
        xact(1'b1, 39'h00, 8'hFF, 64'h0);
        gap(1);
        xact(1'b1, 39'h08, 8'hFF, 64'h5);
        gap(8);
        xact(1'b0, 39'h18, 8'h00, 64'h0);
        gap(1);

        for (int n = 0; n < 300; n++) begin
            sel = 2'($urandom_range(0, 3));
            a = AW'({$urandom(), $urandom()});
            a[4:3] = sel;
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
            r = $urandom_range(0, 19);
            s = (r < 10) ? 8'hFF : (r < 13) ? 8'h00 : 8'($urandom());
            case (sel)
                2'd0: d = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                                      : 64'($urandom_range(0, 200));
                2'd1: d = m_at(cyc) + 64'($urandom_range(0, 30));
                2'd2: d = {$urandom(), 16'($urandom()), 6'($urandom_range(0, 3)),
                           9'($urandom()), 1'($urandom_range(0, 3) != 0)};
                default: d = {$urandom(), $urandom()};
            endcase
            xact(1'($urandom_range(0, 1)), a, s, d);
            gap($urandom_range(1, 3));
        end

        gap(2);
        mon_en = 1'b0;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        // Reset in the grant cycle drops the response.
        @(negedge clk);
        req = 1'b1; wen = 1'b0; addr = 39'h08; g_reset = 1'b1;
        @(negedge clk);
        req = 1'b0;
        #1;
        check("rst_drop_rdata", rdata, 64'h0);
        check("rst_drop_err", {63'h0, err}, 64'h0);
        g_reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
